reset_conditioner: RTL and testbench
====================================

# reset_conditioner

Board-level reset front end for the ECP5 build. It synchronizes and debounces the raw reset push-button and generates a power-on reset, then drives a clean, stretched reset into the reset input of `Risco_5_SOC`. It is the stage directly upstream of the SoC reset pin. It replaces the current tie-off of that pin to `1'b0`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required to accept a button change (10 ms at 25 MHz). Must be ≥1.
- `STRETCH_CYCLES`, default 16: cycles `soc_reset` stays high after the debounced button releases. Must be ≥1.
- `POR_CYCLES`, default 1024: power-on / post-reset hold length. Must be ≥1.
- `SYNC_STAGES`, default 2: synchronizer depth. Must be ≥2.
- `BUTTON_ACTIVE_LOW`, default 0: 1 means the pad reads 0 when pressed.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: synchronous, active-high block reset.
- `button`, input, 1: raw asynchronous button pad.
- `soc_reset`, output, 1: conditioned active-high reset to the SoC. Registered.
- `debounced`, output, 1: debounced button level, normalized so 1 means pressed. Registered.
- `button_pressed`, output, 1: one-cycle pulse on each accepted press. Registered.

## Operation
**Synchronizer and polarity**
- `button` passes through `SYNC_STAGES` flops, then is normalized by `BUTTON_ACTIVE_LOW` to give `btn_s`.
- The synchronizer flops initialize and reset to the inactive pad level.

**Debouncer**
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- While `btn_s != debounced`, the counter increments each cycle.
- If the counter equals `DEBOUNCE_CYCLES-1` on an edge where `btn_s` still differs, then on that edge:
  - `debounced` takes the value of `btn_s`;
  - the counter clears;
  - `button_pressed` pulses for one cycle if the change was 0→1.
- Any cycle where `btn_s == debounced` clears the counter.

**FSM**
- POR:
  - `soc_reset`=1.
  - The POR counter runs 0..`POR_CYCLES-1`.
  - At the terminal count the FSM goes to ASSERT if `debounced`=1, otherwise to IDLE.
- IDLE:
  - `soc_reset`=0.
  - A rising edge of `debounced` moves the FSM to ASSERT.
- ASSERT:
  - `soc_reset`=1.
  - Held while `debounced`=1.
  - A falling edge moves the FSM to STRETCH and clears the stretch counter.
- STRETCH:
  - `soc_reset`=1.
  - The counter runs 0..`STRETCH_CYCLES-1`, then the FSM goes to IDLE.
  - If `debounced` rises during STRETCH, the FSM goes to ASSERT and the counter clears.

**Reset and power-up**
- `reset`=1 on an edge forces all of the following, regardless of the current state:
  - FSM to POR;
  - all counters to 0;
  - `debounced`=0 and `button_pressed`=0;
  - `soc_reset`=1;
  - synchronizer flops to inactive.
- While `reset` is held, the POR counter does not advance.
- Reset values of outputs: `soc_reset`=1, `debounced`=0, `button_pressed`=0.
- Register initial values equal the reset values. With `reset` tied low, FPGA configuration therefore yields a full POR sequence.

## Timing
- Press latency: with the button held stable from cycle 0, `btn_s`=1 after edge `SYNC_STAGES`.
  - `debounced` rises at edge `SYNC_STAGES+DEBOUNCE_CYCLES`.
  - `button_pressed` is high for the cycle following that edge.
  - `soc_reset` rises at edge `SYNC_STAGES+DEBOUNCE_CYCLES+1`.
- Release latency is symmetric: `debounced` falls `SYNC_STAGES+DEBOUNCE_CYCLES` edges after a stable release. `soc_reset` then stays high for exactly `STRETCH_CYCLES` further cycles.
- POR: after `reset` deasserts, `soc_reset` stays high for exactly `POR_CYCLES` cycles.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles produces no change on any output.
- `soc_reset` never glitches low between ASSERT and STRETCH, or when STRETCH re-enters ASSERT.

## Structure
- State encodings (POR, IDLE, ASSERT, STRETCH) are localparams inside this module. There are no shared typedefs.
- The `fpga/ecp5` top instantiates `reset_conditioner` and routes `soc_reset` to the SoC `reset` input.
- One sub-module is natural: `button_debouncer`. It contains the synchronizer, polarity normalization and debounce counter, and produces `debounced` and `button_pressed`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=8, `STRETCH_CYCLES`=4, `POR_CYCLES`=16, `SYNC_STAGES`=2.
- **Reset and POR:** `reset` high for 3 cycles, then low, button idle → `soc_reset`=1 throughout reset, then for exactly 16 cycles, then 0. `button_pressed` never pulses.
- **Clean press:** after POR, press at cycle 0 and hold 30 cycles → `debounced` rises at edge 10, `button_pressed` is high 1 cycle, `soc_reset` rises at edge 11. On release, `debounced` falls 10 edges later, and `soc_reset` is high for 4 more cycles, then 0.
- **Bounce rejection:** toggle `button` every 3 cycles for 30 cycles, then release → `debounced`, `soc_reset` and `button_pressed` stay 0.
- **Re-press in STRETCH:** re-press so that `debounced` rises during the 4-cycle stretch → `soc_reset` stays continuously 1 and the FSM returns to ASSERT.
- **Active-low polarity:** `BUTTON_ACTIVE_LOW`=1, pad idle at 1 → no reset after POR. Drive the pad to 0 → same timing as the clean-press scenario.
- **Reset mid-operation:** assert `reset` during ASSERT with the button released → next edge gives `debounced`=0 and `soc_reset`=1. After `reset` deasserts, 16 POR cycles, then `soc_reset`=0.

Source files
------------

// File: rtl/reset_conditioner_pkg.sv
// Shared helpers for the board reset front end.
package reset_conditioner_pkg;

    // Bits needed to hold a count of 0..n-1. The result is at least 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the raw button pad and normalizes its polarity.
// Accepts a new level only after it has been stable for DEBOUNCE_CYCLES samples.
module button_debouncer
    import reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic debounced_o,
    output logic button_pressed_o
);

    localparam int unsigned            CNT_W     = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{BUTTON_ACTIVE_LOW}};

    // Power-up values match the reset values, so FPGA configuration behaves like a reset.
    logic [SYNC_STAGES-1:0] sync_q = SYNC_IDLE;
    logic [CNT_W-1:0]       cnt_q  = '0;
    logic                   deb_q  = 1'b0;
    logic                   prs_q  = 1'b0;
    logic [CNT_W-1:0]       cnt_d;
    logic                   deb_d;
    logic                   prs_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1] ^ BUTTON_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= SYNC_IDLE;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            prs_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            prs_q  <= prs_d;
        end
    end

    // Count consecutive differing samples; any agreeing sample restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        prs_d = 1'b0;
        if (btn_s != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = btn_s;
                cnt_d = '0;
                prs_d = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign debounced_o      = deb_q;
    assign button_pressed_o = prs_q;

endmodule

// File: rtl/reset_conditioner.sv
// Board reset front end: power-on hold, debounced push-button reset and
// release stretching, producing a clean registered reset for the SoC.
module reset_conditioner
    import reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned STRETCH_CYCLES    = 16,
    parameter int unsigned POR_CYCLES        = 1024,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic soc_reset,
    output logic debounced,
    output logic button_pressed
);

    localparam logic [1:0] ST_POR     = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_ASSERT  = 2'd2;
    localparam logic [1:0] ST_STRETCH = 2'd3;

    localparam int unsigned      POR_W    = cnt_width(POR_CYCLES);
    localparam int unsigned      STR_W    = cnt_width(STRETCH_CYCLES);
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);

    logic [1:0]       state_q     = ST_POR;
    logic [POR_W-1:0] por_cnt_q   = '0;
    logic [STR_W-1:0] str_cnt_q   = '0;
    logic             soc_reset_q = 1'b1;
    logic [1:0]       state_d;
    logic [POR_W-1:0] por_cnt_d;
    logic [STR_W-1:0] str_cnt_d;
    logic             soc_reset_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .SYNC_STAGES      (SYNC_STAGES),
        .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
    ) u_debouncer (
        .clk             (clk),
        .reset           (reset),
        .button_i        (button),
        .debounced_o     (debounced),
        .button_pressed_o(button_pressed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POR;
            por_cnt_q   <= '0;
            str_cnt_q   <= '0;
            soc_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            str_cnt_q   <= str_cnt_d;
            soc_reset_q <= soc_reset_d;
        end
    end

    // Reset is asserted in every state except IDLE, so ASSERT<->STRETCH never glitches.
    always_comb begin
        state_d   = state_q;
        por_cnt_d = por_cnt_q;
        str_cnt_d = str_cnt_q;
        case (state_q)
            ST_POR: begin
                if (por_cnt_q == POR_LAST) begin
                    por_cnt_d = '0;
                    state_d   = debounced ? ST_ASSERT : ST_IDLE;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end
            ST_IDLE: begin
                if (debounced) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!debounced) begin
                    state_d   = ST_STRETCH;
                    str_cnt_d = '0;
                end
            end
            ST_STRETCH: begin
                if (debounced) begin
                    state_d   = ST_ASSERT;
                    str_cnt_d = '0;
                end else if (str_cnt_q == STR_LAST) begin
                    state_d   = ST_IDLE;
                    str_cnt_d = '0;
                end else begin
                    str_cnt_d = str_cnt_q + STR_W'(1);
                end
            end
            default: state_d = ST_POR;
        endcase
        soc_reset_d = (state_d != ST_IDLE);
    end

    assign soc_reset = soc_reset_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Scoreboard bench: stimulus queues the expected output changes with their edge
// numbers, and a monitor checks every observed change against that queue.
module tb_reset_conditioner;

    localparam int DEB     = 8;
    localparam int SYNC    = 2;
    localparam int STR     = 4;
    localparam int STR_C   = 16;
    localparam int POR     = 16;
    localparam int LAT     = SYNC + DEB;
    localparam int DUT_A   = 0;
    localparam int DUT_B   = 1;
    localparam int DUT_C   = 2;

    typedef struct packed {
        int         at;
        logic [8:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic reset_a, reset_b, reset_c;
    logic button_a, button_b, button_c;
    logic soc_a, deb_a, prs_a;
    logic soc_b, deb_b, prs_b;
    logic soc_c, deb_c, prs_c;
    logic [8:0] outs;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  evq[$];
    logic [8:0] exp_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: active-high button. B: active-low pad. C: stretch longer than the
    // debounce window, so a re-press can land inside the stretch.
    reset_conditioner #(.DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .POR_CYCLES(POR),
                        .SYNC_STAGES(SYNC), .BUTTON_ACTIVE_LOW(1'b0)) u_dut_a (
        .clk(clk), .reset(reset_a), .button(button_a),
        .soc_reset(soc_a), .debounced(deb_a), .button_pressed(prs_a));

    reset_conditioner #(.DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .POR_CYCLES(POR),
                        .SYNC_STAGES(SYNC), .BUTTON_ACTIVE_LOW(1'b1)) u_dut_b (
        .clk(clk), .reset(reset_b), .button(button_b),
        .soc_reset(soc_b), .debounced(deb_b), .button_pressed(prs_b));

    reset_conditioner #(.DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR_C), .POR_CYCLES(POR),
                        .SYNC_STAGES(SYNC), .BUTTON_ACTIVE_LOW(1'b0)) u_dut_c (
        .clk(clk), .reset(reset_c), .button(button_c),
        .soc_reset(soc_c), .debounced(deb_c), .button_pressed(prs_c));

    assign outs = {soc_a, deb_a, prs_a, soc_b, deb_b, prs_b, soc_c, deb_c, prs_c};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record that after edge 'at', DUT 'dut' shows {soc_reset, debounced, button_pressed} = v.
    function automatic void expect_ev(input int at, input int dut, input logic [2:0] v);
        ev_t e;
        exp_v[(2 - dut) * 3 +: 3] = v;
        if (evq.size() != 0 && evq[evq.size() - 1].at == at) begin
            e = evq.pop_back();
            e.vec = exp_v;
            evq.push_back(e);
        end else begin
            e.at  = at;
            e.vec = exp_v;
            evq.push_back(e);
        end
    endfunction

    initial begin : monitor
        logic [8:0] cur;
        logic [8:0] prev;
        ev_t        e;
        @(negedge clk);
        prev = outs;
        checks++;
        if (prev !== 9'b100_100_100) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", prev, 9'b100_100_100);
        end
        forever begin
            @(negedge clk);
            cur = outs;
            if (cur !== prev) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: edge %0d got %b, no change expected (was %b)",
                             cyc, cur, prev);
                end else begin
                    e = evq.pop_front();
                    if (cyc != e.at || cur !== e.vec) begin
                        errors++;
                        $display("FAIL output_event: got %b at edge %0d, expected %b at edge %0d",
                                 cur, cyc, e.vec, e.at);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        int p, q, r, s, t, m;
        reset_a  = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        button_a = 1'b0; button_b = 1'b1; button_c = 1'b0;
        exp_v    = 9'b100_100_100;

        // Reset for 3 edges, then exactly POR cycles of soc_reset on all DUTs.
        tick(3);
        r = cyc;
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        expect_ev(r + POR, DUT_A, 3'b000);
        expect_ev(r + POR, DUT_B, 3'b000);
        expect_ev(r + POR, DUT_C, 3'b000);
        tick(25);

        // Clean press and release on A.
        p = cyc; button_a = 1'b1;
        expect_ev(p + LAT,     DUT_A, 3'b011);
        expect_ev(p + LAT + 1, DUT_A, 3'b110);
        tick(30);
        q = cyc; button_a = 1'b0;
        expect_ev(q + LAT,           DUT_A, 3'b100);
        expect_ev(q + LAT + 1 + STR, DUT_A, 3'b000);
        tick(25);

        // Bounce every 3 cycles: no output may move.
        for (int i = 0; i < 10; i++) begin
            button_a = ~button_a;
            tick(3);
        end
        button_a = 1'b0;
        tick(20);

        // Active-low pad on B: same timing as the clean press.
        p = cyc; button_b = 1'b0;
        expect_ev(p + LAT,     DUT_B, 3'b011);
        expect_ev(p + LAT + 1, DUT_B, 3'b110);
        tick(30);
        q = cyc; button_b = 1'b1;
        expect_ev(q + LAT,           DUT_B, 3'b100);
        expect_ev(q + LAT + 1 + STR, DUT_B, 3'b000);
        tick(25);

        // Re-press on C so debounced rises inside the stretch; soc_reset must stay high.
        p = cyc; button_c = 1'b1;
        expect_ev(p + LAT,     DUT_C, 3'b011);
        expect_ev(p + LAT + 1, DUT_C, 3'b110);
        tick(20);
        q = cyc; button_c = 1'b0;
        expect_ev(q + LAT, DUT_C, 3'b100);
        tick(9);
        s = cyc; button_c = 1'b1;
        expect_ev(s + LAT,     DUT_C, 3'b111);
        expect_ev(s + LAT + 1, DUT_C, 3'b110);
        // Held past where the first stretch would have ended, then a full fresh stretch.
        tick(20);
        t = cyc; button_c = 1'b0;
        expect_ev(t + LAT,             DUT_C, 3'b100);
        expect_ev(t + LAT + 1 + STR_C, DUT_C, 3'b000);
        tick(35);

        // Reset during ASSERT with button released.
        p = cyc; button_a = 1'b1;
        expect_ev(p + LAT,     DUT_A, 3'b011);
        expect_ev(p + LAT + 1, DUT_A, 3'b110);
        tick(20);
        m = cyc; button_a = 1'b0; reset_a = 1'b1;
        expect_ev(m + 1, DUT_A, 3'b100);
        tick(2);
        r = cyc; reset_a = 1'b0;
        expect_ev(r + POR, DUT_A, 3'b000);
        tick(25);

        @(negedge clk);
        #1;
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected changes never seen (next at edge %0d), expected 0",
                     evq.size(), evq[0].at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
